regwb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file and shares it between two requesters.
- Requester A is the pipeline writeback stage: fixed priority, no backpressure.
- Requester B is a long-latency unit (multiply/divide, uncached load). Its results are queued in a small FIFO and drained into idle write-port cycles.
- Also keeps a per-register busy scoreboard for outstanding long-latency results, so decode can stall on RAW/WAW against them.

---
 rtl/regwb_arbiter.sv | 79 +++++++
 tb/tb_regwb_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: shares the register-file write port between pipeline writeback and a queued long-latency unit, with a busy scoreboard.
module regwb_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_wrreg,
  input  logic [31:0] wb_wrdata,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_wrreg,
  input  logic [31:0] lu_wrdata,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        hazard,
  output logic        starve_stall,
  output logic [31:0] busy,
  output logic        regwrite,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_n;
  logic [SW-1:0] starve;
  logic          a_act, empty, push, pop;
  logic [4:0]    head_reg;
  logic [31:0]   head_data, busy_n;
  always_comb begin
    a_act     = wb_regwrite && wb_wrreg != 5'd0;
    empty     = count == '0;
    head_reg  = fifo_reg[rptr];
    head_data = fifo_data[rptr];
    push      = lu_valid && lu_ready;
    pop       = !a_act && !empty;
    count_n   = count + (AW+1)'(push) - (AW+1)'(pop);
    regwrite  = a_act || (!empty && head_reg != 5'd0);
    wrreg     = a_act ? wb_wrreg : (!empty ? head_reg : 5'd0);
    wrdata    = a_act ? wb_wrdata : (!empty ? head_data : 32'd0);
    hazard    = busy[chk_reg1] | busy[chk_reg2];
    busy_n    = busy;
    // clear before set so a same-cycle issue to the popped register keeps it busy
    if (pop) busy_n[head_reg] = 1'b0;
    if (iss_valid) busy_n[iss_reg] = 1'b1;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (push) begin
      fifo_reg[wptr]  <= lu_wrreg;
      fifo_data[wptr] <= lu_wrdata;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      lu_ready     <= 1'b1;
      busy         <= '0;
      starve       <= '0;
      starve_stall <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count        <= count_n;
      lu_ready     <= count_n != (AW+1)'(DEPTH);
      busy         <= busy_n;
      starve       <= (pop || empty) ? '0 :
                      (a_act && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
      starve_stall <= pop ? 1'b0 : (starve_stall | (starve == SW'(STARVE_MAX)));
    end
  end
endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: directed checks of write-port arbitration, FIFO, scoreboard and starvation.
module tb_regwb_arbiter;
  logic clk = 0, reset;
  logic wb_regwrite, lu_valid, lu_ready, iss_valid, hazard, starve_stall, regwrite;
  logic [4:0] wb_wrreg, lu_wrreg, iss_reg, chk_reg1, chk_reg2, wrreg;
  logic [31:0] wb_wrdata, lu_wrdata, busy, wrdata;
  int tests = 0, fails = 0;
  regwb_arbiter dut (
    .clk(clk), .reset(reset), .wb_regwrite(wb_regwrite), .wb_wrreg(wb_wrreg), .wb_wrdata(wb_wrdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wrreg(lu_wrreg), .lu_wrdata(lu_wrdata),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .hazard(hazard), .starve_stall(starve_stall), .busy(busy),
    .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    {reset, wb_regwrite, lu_valid, iss_valid} = '0;
    {wb_wrreg, lu_wrreg, iss_reg, chk_reg1, chk_reg2} = '0;
    {wb_wrdata, lu_wrdata} = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    settle();
    check("rst_ready", 32'(lu_ready), 1);
    check("rst_busy", busy, 0);
    check("rst_stall", 32'(starve_stall), 0);
    check("rst_regwrite", 32'(regwrite), 0);
    // only A
    wb_regwrite = 1; wb_wrreg = 8; wb_wrdata = 32'h11;
    settle();
    check("a_we", 32'(regwrite), 1);
    check("a_reg", 32'(wrreg), 8);
    check("a_data", wrdata, 32'h11);
    wb_wrreg = 0;
    settle();
    check("a_zero_we", 32'(regwrite), 0);
    check("a_zero_reg", 32'(wrreg), 0);
    tick();
    wb_regwrite = 0;
    check("a_no_busy", busy, 0);
    // only B
    iss_valid = 1; iss_reg = 9;
    tick();
    iss_valid = 0; chk_reg1 = 9;
    settle();
    check("b_busy9", busy, 32'h200);
    check("b_hazard", 32'(hazard), 1);
    chk_reg1 = 3;
    settle();
    check("b_nohazard", 32'(hazard), 0);
    lu_valid = 1; lu_wrreg = 9; lu_wrdata = 32'hDEADBEEF;
    settle();
    check("b_no_bypass", 32'(regwrite), 0);
    tick();
    lu_valid = 0;
    settle();
    check("b_we", 32'(regwrite), 1);
    check("b_reg", 32'(wrreg), 9);
    check("b_data", wrdata, 32'hDEADBEEF);
    check("b_busy_held", busy, 32'h200);
    tick();
    check("b_busy_clr", busy, 0);
    check("b_idle", 32'(regwrite), 0);
    // contention
    wb_regwrite = 1; wb_wrreg = 5; wb_wrdata = 32'hA;
    lu_valid = 1; lu_wrreg = 3; lu_wrdata = 32'h33;
    tick();
    lu_wrreg = 4; lu_wrdata = 32'h44;
    settle();
    check("c_a_wins", 32'(wrreg), 5);
    check("c_ready1", 32'(lu_ready), 1);
    tick();
    lu_valid = 0;
    settle();
    check("c_full", 32'(lu_ready), 0);
    check("c_stall2", 32'(starve_stall), 0);
    lu_valid = 1; lu_wrreg = 7; lu_wrdata = 32'h77;
    tick();
    lu_valid = 0;
    check("c_stall3", 32'(starve_stall), 0);
    tick();
    check("c_stall4", 32'(starve_stall), 0);
    tick();
    check("c_stall5", 32'(starve_stall), 0);
    tick();
    check("c_stall6", 32'(starve_stall), 1);
    wb_regwrite = 0;
    settle();
    check("c_head_reg", 32'(wrreg), 3);
    check("c_head_data", wrdata, 32'h33);
    check("c_stall_pop", 32'(starve_stall), 1);
    check("c_ready_pop", 32'(lu_ready), 0);
    tick();
    check("c_stall_clr", 32'(starve_stall), 0);
    check("c_ready_back", 32'(lu_ready), 1);
    check("c_head2_reg", 32'(wrreg), 4);
    check("c_head2_data", wrdata, 32'h44);
    tick();
    check("c_dropped", 32'(regwrite), 0);
    // same-cycle set and clear
    iss_valid = 1; iss_reg = 10;
    lu_valid = 1; lu_wrreg = 10; lu_wrdata = 32'hAA;
    tick();
    lu_valid = 0;
    settle();
    check("s_pop_reg", 32'(wrreg), 10);
    check("s_busy_pre", busy, 32'h400);
    tick();
    iss_valid = 0; chk_reg1 = 0; chk_reg2 = 10;
    settle();
    check("s_set_wins", busy, 32'h400);
    check("s_hazard2", 32'(hazard), 1);
    // B result to $zero
    lu_valid = 1; lu_wrreg = 0; lu_wrdata = 32'h5;
    tick();
    lu_valid = 0; iss_valid = 1; iss_reg = 0;
    settle();
    check("z_we", 32'(regwrite), 0);
    check("z_reg", 32'(wrreg), 0);
    check("z_data", wrdata, 32'h5);
    tick();
    iss_valid = 0;
    check("z_busy", busy, 32'h400);
    check("z_empty", 32'(regwrite), 0);
    // reset with full FIFO
    reset = 1;
    tick();
    reset = 0;
    iss_valid = 1; iss_reg = 8;
    lu_valid = 1; lu_wrreg = 1; lu_wrdata = 32'h1;
    tick();
    iss_reg = 9; lu_wrreg = 2; lu_wrdata = 32'h2;
    wb_regwrite = 1; wb_wrreg = 5;
    tick();
    iss_valid = 0; lu_valid = 0;
    settle();
    check("r_busy", busy, 32'h300);
    check("r_full", 32'(lu_ready), 0);
    reset = 1; wb_regwrite = 0;
    tick();
    reset = 0;
    settle();
    check("r_ready", 32'(lu_ready), 1);
    check("r_busy0", busy, 0);
    check("r_stall", 32'(starve_stall), 0);
    check("r_regwrite", 32'(regwrite), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
